// File: rtl/exc_ctrl_pkg.sv
// Shared types and encodings for the exception controller.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_JUMP, S_RET} state_t;

  localparam logic [4:0] EXC_INT    = 5'd0;
  localparam logic [4:0] EXC_SYS    = 5'd8;
  localparam logic [4:0] EXC_UNIMPL = 5'd10;
  localparam logic [4:0] EXC_OV     = 5'd12;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

  localparam logic [1:0] PC_NORMAL = 2'b00;
  localparam logic [1:0] PC_VEC    = 2'b01;
  localparam logic [1:0] PC_EPC    = 2'b10;

  function automatic logic [31:0] cause_word(input logic [4:0] code);
    return {25'b0, code, 2'b0};
  endfunction

endpackage

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority encoder: enabled events {ov, unimpl, sys, int} -> {valid, ExcCode}.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic [3:0] ev,
  output logic       valid,
  output logic [4:0] code
);

  always_comb begin
    valid = 1'b1;
    code  = EXC_INT;
    if      (ev[3]) code = EXC_OV;
    else if (ev[2]) code = EXC_UNIMPL;
    else if (ev[1]) code = EXC_SYS;
    else if (ev[0]) code = EXC_INT;
    else            valid = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: IDLE -> SAVE -> JUMP for events, IDLE -> RET for eret.
// Define EXC_INT_SYNC_EN to put a 2-flop synchronizer on Intr.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Intr,
  input  logic        Sys,
  input  logic        Unimpl,
  input  logic        Ov,
  input  logic        Eret,
  input  logic [31:0] Sta,
  output logic        Wcau,
  output logic        Wsta,
  output logic        Wepc,
  output logic [31:0] Cause,
  output logic [1:0]  StaShift,
  output logic        SelEpc,
  output logic [1:0]  SelPc,
  output logic        Flush,
  output logic        Busy,
  output logic        IntAck
);

  state_t     state;
  logic [4:0] code;
  logic       pend;
  logic       intr_s;
  logic       pvalid;
  logic [4:0] pcode;
  logic [3:0] ev;
  logic       unused_sta;

  assign unused_sta = ^Sta[31:4];

`ifdef EXC_INT_SYNC_EN
  logic [1:0] sync_pipe;
  always_ff @(posedge Clk) begin
    if (Rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], Intr};
  end
  assign intr_s = sync_pipe[1];
`else
  assign intr_s = Intr;
`endif

  // Ack clears first; a still-high level re-arms pend on the following edge.
  always_ff @(posedge Clk) begin
    if (Rst)         pend <= 1'b0;
    else if (IntAck) pend <= 1'b0;
    else if (intr_s) pend <= 1'b1;
  end

  assign ev = {Ov & Sta[3], Unimpl & Sta[2], Sys & Sta[1], pend & Sta[0]};

  exc_prio u_prio (
    .ev    (ev),
    .valid (pvalid),
    .code  (pcode)
  );

  // Outputs are loaded together with the state they belong to.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      code     <= EXC_INT;
      Wcau     <= 1'b0;
      Wsta     <= 1'b0;
      Wepc     <= 1'b0;
      StaShift <= SH_HOLD;
      SelEpc   <= 1'b0;
      SelPc    <= PC_NORMAL;
      Flush    <= 1'b0;
      Busy     <= 1'b0;
      IntAck   <= 1'b0;
    end else begin
      Wcau     <= 1'b0;
      Wsta     <= 1'b0;
      Wepc     <= 1'b0;
      StaShift <= SH_HOLD;
      SelEpc   <= 1'b0;
      SelPc    <= PC_NORMAL;
      Flush    <= 1'b0;
      Busy     <= 1'b0;
      IntAck   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pvalid) begin
            state    <= S_SAVE;
            code     <= pcode;
            Wcau     <= 1'b1;
            Wsta     <= 1'b1;
            Wepc     <= 1'b1;
            StaShift <= SH_LEFT;
            SelEpc   <= (pcode == EXC_INT);
            IntAck   <= (pcode == EXC_INT);
            Flush    <= 1'b1;
            Busy     <= 1'b1;
          end else if (Eret) begin
            state    <= S_RET;
            Wsta     <= 1'b1;
            StaShift <= SH_RIGHT;
            SelPc    <= PC_EPC;
            Flush    <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        S_SAVE: begin
          state <= S_JUMP;
          SelPc <= PC_VEC;
          Flush <= 1'b1;
          Busy  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Cause = Wcau ? cause_word(code) : 32'h0;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: vector table for synchronous exceptions, sequences for interrupts/reset.
module tb_exc_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Intr, Sys, Unimpl, Ov, Eret;
  logic [31:0] Sta;
  logic        Wcau, Wsta, Wepc, SelEpc, Flush, Busy, IntAck;
  logic [31:0] Cause;
  logic [1:0]  StaShift, SelPc;

  int checks = 0;
  int errors = 0;

  exc_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Intr(Intr), .Sys(Sys), .Unimpl(Unimpl), .Ov(Ov),
    .Eret(Eret), .Sta(Sta), .Wcau(Wcau), .Wsta(Wsta), .Wepc(Wepc), .Cause(Cause),
    .StaShift(StaShift), .SelEpc(SelEpc), .SelPc(SelPc), .Flush(Flush),
    .Busy(Busy), .IntAck(IntAck)
  );

  always #5 Clk = ~Clk;

  // {Wcau,Wsta,Wepc,SelEpc,Flush,Busy,IntAck,StaShift,SelPc,Cause}
  logic [42:0] obs;
  assign obs = {Wcau, Wsta, Wepc, SelEpc, Flush, Busy, IntAck, StaShift, SelPc, Cause};

  typedef enum int {K_IDLE, K_SAVE, K_INT, K_JUMP, K_RET} kind_t;

  typedef struct {
    logic        rst, sys, unimpl, ov, eret;
    logic [3:0]  sta;
    kind_t       kind;
    logic [31:0] cause;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [42:0] expect_of(kind_t k, logic [31:0] c);
    case (k)
      K_SAVE:  return {7'b1110110, 2'b01, 2'b00, c};
      K_INT:   return {7'b1111111, 2'b01, 2'b00, 32'h0};
      K_JUMP:  return {7'b0000110, 2'b00, 2'b01, 32'h0};
      K_RET:   return {7'b0100110, 2'b10, 2'b10, 32'h0};
      default: return 43'h0;
    endcase
  endfunction

  task automatic add(input logic rst, sys, unimpl, ov, eret, input logic [3:0] sta,
                     input kind_t k, input logic [31:0] c);
    vec_t v;
    v.rst = rst; v.sys = sys; v.unimpl = unimpl; v.ov = ov; v.eret = eret;
    v.sta = sta; v.kind = k; v.cause = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rst = 0; Intr = 0; Sys = 0; Unimpl = 0; Ov = 0; Eret = 0;
  endtask

  // Wait for a SAVE cycle; returns edges taken, or 0 on timeout.
  task automatic wait_save(input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (Wcau) begin n = i; break; end
    end
  endtask

  int n;
  logic anybusy;

  initial begin
    idle_inputs();
    Sta = 32'h0;

    //   rst sys un ov eret sta   kind    cause
    add(1, 0, 0, 0, 0, 4'hF, K_IDLE, 0);        // reset state
    add(0, 0, 0, 0, 0, 4'hF, K_IDLE, 0);
    add(0, 0, 0, 1, 0, 4'hF, K_SAVE, 32'h30);   // overflow
    add(0, 0, 0, 0, 0, 4'hF, K_JUMP, 0);
    add(0, 0, 0, 0, 0, 4'hF, K_IDLE, 0);
    add(0, 0, 0, 0, 1, 4'hF, K_RET,  0);        // eret
    add(0, 0, 0, 0, 0, 4'hF, K_IDLE, 0);
    add(0, 0, 1, 0, 1, 4'hF, K_SAVE, 32'h28);   // event beats eret
    add(0, 0, 0, 1, 0, 4'hF, K_JUMP, 0);        // ignored while busy
    add(0, 0, 0, 0, 1, 4'hF, K_IDLE, 0);        // eret ignored in JUMP
    add(0, 1, 0, 0, 0, 4'hF, K_SAVE, 32'h20);   // syscall
    add(0, 0, 0, 0, 0, 4'hF, K_JUMP, 0);
    add(0, 0, 0, 0, 0, 4'hF, K_IDLE, 0);
    add(0, 0, 0, 1, 0, 4'h0, K_IDLE, 0);        // disabled overflow
    add(0, 1, 1, 1, 0, 4'h2, K_SAVE, 32'h20);   // only sys enabled
    add(0, 0, 0, 0, 0, 4'hF, K_JUMP, 0);
    add(1, 0, 0, 0, 0, 4'hF, K_IDLE, 0);        // reset mid-JUMP
    add(0, 1, 1, 1, 0, 4'hF, K_SAVE, 32'h30);   // priority: ov wins
    add(1, 0, 0, 0, 0, 4'hF, K_IDLE, 0);        // reset mid-SAVE
    add(0, 1, 1, 0, 0, 4'hC, K_SAVE, 32'h28);   // unimpl, sys disabled
    add(0, 0, 0, 0, 0, 4'hF, K_JUMP, 0);
    add(0, 0, 0, 0, 0, 4'hF, K_IDLE, 0);
    add(0, 0, 0, 1, 1, 4'h0, K_RET,  0);        // disabled event, eret goes
    add(0, 0, 0, 0, 0, 4'hF, K_IDLE, 0);

    foreach (tbl[i]) begin
      Rst = tbl[i].rst; Sys = tbl[i].sys; Unimpl = tbl[i].unimpl;
      Ov = tbl[i].ov; Eret = tbl[i].eret; Sta = {28'h0, tbl[i].sta};
      step();
      chk($sformatf("vec%0d", i), {21'h0, obs}, {21'h0, expect_of(tbl[i].kind, tbl[i].cause)});
    end
    idle_inputs();

    // Interrupt latency from first sampling edge to SAVE
    Sta = 32'hF; Intr = 1;
    step();
    chk("int_not_immediate", {63'h0, Busy}, 64'h0);
    Intr = 0;
    wait_save(8, n);
`ifdef EXC_INT_SYNC_EN
    chk("int_latency", n, 3);
`else
    chk("int_latency", n, 1);
`endif
    chk("int_save", {21'h0, obs}, {21'h0, expect_of(K_INT, 0)});
    step();
    chk("int_jump", {21'h0, obs}, {21'h0, expect_of(K_JUMP, 0)});
    anybusy = 0;
    for (int i = 0; i < 5; i++) begin step(); anybusy |= Busy; end
    chk("int_acked_once", {63'h0, anybusy}, 64'h0);

    // Syscall and interrupt together: sys first, interrupt after returning to IDLE
    Sys = 1; Intr = 1;
    step();
    chk("both_sys_save", {21'h0, obs}, {21'h0, expect_of(K_SAVE, 32'h20)});
    Sys = 0; Intr = 0;
    step();
    chk("both_sys_jump", {21'h0, obs}, {21'h0, expect_of(K_JUMP, 0)});
    step();
    chk("both_idle", {21'h0, obs}, 64'h0);
    wait_save(6, n);
    chk("both_int_taken", {63'h0, (n != 0)}, 64'h1);
    chk("both_int_save", {21'h0, obs}, {21'h0, expect_of(K_INT, 0)});
    step(); step();

    // Disabled interrupt keeps pend until enabled
    Sta = 32'h0; Intr = 1;
    step();
    Intr = 0;
    anybusy = 0;
    for (int i = 0; i < 5; i++) begin step(); anybusy |= Busy; end
    chk("masked_int_idle", {63'h0, anybusy}, 64'h0);
    Sta = 32'h1;
    step();
    chk("unmasked_int_save", {21'h0, obs}, {21'h0, expect_of(K_INT, 0)});
    step(); step();

    // Reset clears pending interrupt
    Sta = 32'h0; Intr = 1;
    step();
    Intr = 0;
    for (int i = 0; i < 4; i++) step();
    Rst = 1;
    step();
    chk("rst_outputs", {21'h0, obs}, 64'h0);
    Rst = 0; Sta = 32'h1;
    anybusy = 0;
    for (int i = 0; i < 5; i++) begin step(); anybusy |= Busy; end
    chk("rst_clears_pend", {63'h0, anybusy}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The port list SHALL be: Clk in 1, rising-edge clock; Rst in 1, reset, synchronous and active-high.
REQ-002 The block SHALL have the input Intr, 1 bit: external interrupt request, level.
REQ-003 The block SHALL have the inputs Sys, Unimpl and Ov, 1 bit each: syscall, unimplemented-opcode and arithmetic-overflow indications for the instruction in ID/EX.
REQ-004 The block SHALL have the input Eret, 1 bit: exception-return instruction decoded.
REQ-005 The block SHALL have the input Sta, 32 bits: current STATUS value; bits [3:0] are enables Int/Sys/Unimpl/Ov.
REQ-006 The block SHALL have the outputs Wcau, Wsta and Wepc, 1 bit each: write enables for CAUSE, STATUS and EPC.
REQ-007 The block SHALL have the output Cause, 32 bits: value to load into CAUSE; ExcCode in [6:2], all other bits 0.
REQ-008 The block SHALL have the output StaShift, 2 bits: 00 hold, 01 shift STATUS left 4, 10 shift STATUS right 4.
REQ-009 The block SHALL have the output SelEpc, 1 bit: 0 selects faulting PC, 1 selects next PC.
REQ-010 The block SHALL have the output SelPc, 2 bits: 00 normal, 01 exception vector 0x00000008, 10 EPC.
REQ-011 The block SHALL have the outputs Flush, Busy and IntAck, 1 bit each: pipeline flush, controller not idle, interrupt accepted (1-cycle pulse).

Function
REQ-012 The FSM states SHALL be IDLE, SAVE, JUMP and RET, and the FSM SHALL update only on rising Clk.
REQ-013 An enabled event is Ov&Sta[3], Unimpl&Sta[2], Sys&Sta[1], or Pend&Sta[0]; Pend is a flop set by Intr=1 and cleared on IntAck.
REQ-014 In IDLE with one or more enabled events, the FSM SHALL go to SAVE and latch the winner by fixed priority Ov > Unimpl > Sys > Int.
REQ-015 The ExcCode latched on entry to SAVE SHALL be Int=0, Sys=8, Unimpl=10, Ov=12.
REQ-016 In IDLE with Eret=1 and no enabled event, the FSM SHALL go to RET; an enabled event wins over a simultaneous Eret.
REQ-017 SAVE SHALL last exactly 1 cycle and assert Wcau=Wepc=Wsta=1, StaShift=01, Flush=1, and Cause={25'b0,ExcCode,2'b0}.
REQ-018 In SAVE, SelEpc SHALL be 1 for an interrupt and 0 otherwise, and IntAck SHALL be 1 for an interrupt.
REQ-019 JUMP SHALL last exactly 1 cycle with SelPc=01 and Flush=1, then return to IDLE.
REQ-020 RET SHALL last exactly 1 cycle with Wsta=1, StaShift=10, SelPc=10 and Flush=1, then return to IDLE.
REQ-021 Latency from an enabled event sampled in IDLE to the vector fetch SHALL be 2 cycles.
REQ-022 Busy SHALL be 1 in SAVE, JUMP and RET.
REQ-023 Sys/Unimpl/Ov/Eret SHALL be ignored while Busy, since those instructions are flushed; Pend SHALL persist and be taken in the next IDLE if still enabled.
REQ-024 Outputs not stated for a state SHALL be 0 in that state; all outputs SHALL be registered-state decodes with no combinational path from Intr.
REQ-025 A disabled event (enable bit 0) SHALL cause no state change; a disabled interrupt SHALL keep Pend set.

Reset
REQ-026 Rst=1 at a rising Clk SHALL force IDLE, Pend=0 and the latched ExcCode to 0, including mid-SAVE/JUMP/RET, aborting any partial sequence.
REQ-027 During and after reset, every output SHALL be 0 until an event is accepted.

Configuration
REQ-028 With EXC_INT_SYNC_EN defined, Intr SHALL pass through a 2-flop synchronizer (reset to 0) before setting Pend, adding 2 cycles of interrupt latency.
REQ-029 Without EXC_INT_SYNC_EN, Intr SHALL set Pend directly at the next edge; synchronous exception timing SHALL be identical in both builds.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, ExcCode constants (0, 8, 10, 12), the vector address 0x00000008, and the StaShift/SelPc encodings.
REQ-031 One sub-module, exc_prio, SHALL be the combinational priority encoder mapping enabled events to {valid, ExcCode}.

Verification
REQ-032 Sta=0x0000000F, Ov=1 for 1 cycle -> SAVE with Cause=0x00000030, Wcau/Wepc/Wsta=1, StaShift=01, SelEpc=0; next cycle SelPc=01; then IDLE.
REQ-033 Sta=0xF, Sys=1 and Intr=1 in the same cycle -> Cause=0x20 taken first; after return to IDLE, interrupt SAVE with Cause=0x00, SelEpc=1 and IntAck pulse.
REQ-034 Sta=0x0, Intr=1 pulse -> no transition and Pend stays 1; then set Sta=0x1 -> SAVE within 1 cycle.
REQ-035 In IDLE, Eret=1 with no events -> RET: Wsta=1, StaShift=10, SelPc=10, Flush=1 for 1 cycle; Eret and Unimpl with Sta[2]=1 together -> Cause=0x28 and no RET.
REQ-036 Rst=1 asserted during JUMP -> next cycle IDLE, all outputs 0, Pend=0.
REQ-037 With EXC_INT_SYNC_EN defined, Intr rising to SAVE takes 3 cycles; without it, 1 cycle.
